// File: rtl/btn_pulse_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : btn_pulse_conditioner
// Description : Per-button synchronizer, debounce FSM and hold-to-repeat
//               generator. Produces a debounced level plus one-cycle
//               press/release pulses for downstream control logic.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_pulse_conditioner #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int REPEAT_DELAY    = 62500000,
  parameter int REPEAT_PERIOD   = 25000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  input  logic             repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // One counter width serves both the debounce and repeat counters; it is
  // sized for the largest limit so a single shared increment constant works.
  localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_LIM = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int CNT_W   = ($clog2(MAX_LIM) < 1) ? 1 : $clog2(MAX_LIM);

  localparam logic [CNT_W-1:0] DB_LIM  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LIM  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LIM  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_HELD         = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       rcnt_q, rcnt_d;
    logic [CNT_W-1:0]       rep_lim;
    logic                   periodic_q, periodic_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;

    // Metastability guard: shift the raw asynchronous input through a flop chain.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn[i]};
      end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Next-state logic: debounce both edges, generate press on acceptance and
    // on every auto-repeat interval while the button stays held.
    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rcnt_d     = rcnt_q;
      periodic_d = periodic_q;
      level_d    = level_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      rep_lim    = periodic_q ? RP_LIM : RD_LIM;

      case (state_q)
        S_IDLE: begin
          if (sync) begin
            state_d = S_PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        S_PRESS_WAIT: begin
          if (!sync) begin
            state_d = S_IDLE;
          end else if (cnt_q == DB_LIM) begin
            state_d    = S_HELD;
            level_d    = 1'b1;
            press_d    = 1'b1;
            rcnt_d     = '0;
            periodic_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_HELD: begin
          if (!sync) begin
            state_d = S_RELEASE_WAIT;
            cnt_d   = '0;
          end else if (repeat_en) begin
            if (rcnt_q == rep_lim) begin
              press_d    = 1'b1;
              rcnt_d     = '0;
              periodic_d = 1'b1;
            end else begin
              rcnt_d = rcnt_q + CNT_ONE;
            end
          end else begin
            // Repeat disabled: discard any progress toward the next repeat.
            rcnt_d     = '0;
            periodic_d = 1'b0;
          end
        end
        S_RELEASE_WAIT: begin
          // A bounce back to pressed resumes repeat timing where it paused.
          if (sync) begin
            state_d = S_HELD;
          end else if (cnt_q == DB_LIM) begin
            state_d   = S_IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          level_d = 1'b0;
        end
      endcase
    end

    // State and output registers; pulses are registered so they are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q    <= S_IDLE;
        cnt_q      <= '0;
        rcnt_q     <= '0;
        periodic_q <= 1'b0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        rcnt_q     <= rcnt_d;
        periodic_q <= periodic_d;
        level_q    <= level_d;
        press_q    <= press_d;
        release_q  <= release_d;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_pulse_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_pulse_conditioner
// Description : Directed, table-driven bench for btn_pulse_conditioner with
//               hand-written reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_pulse_conditioner;

  logic       clk;
  logic       rst;
  logic [1:0] btn;
  logic       repeat_en;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;

  int total_checks;
  int passed_checks;

  btn_pulse_conditioner #(
    .N_BTN           (2),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5),
    .SYNC_STAGES     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .repeat_en   (repeat_en),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record covers n consecutive edges with constant inputs and outputs.
  typedef struct {
    logic [1:0] btn;
    logic       ren;
    int         n;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] b, input logic r, input int n,
                              input logic [1:0] l, input logic [1:0] p,
                              input logic [1:0] q);
    vec_t v;
    v.btn = b; v.ren = r; v.n = n; v.lvl = l; v.prs = p; v.rel = q;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [5:0] act, input logic [5:0] exp);
    total_checks++;
    if (act === exp) begin
      passed_checks++;
    end else begin
      $display("FAIL %s[%0d] {level,press,release}: got %b want %b", name, idx, act, exp);
    end
  endtask

  // Advance one edge and compare outputs 1 time unit after it.
  task automatic edge_chk(input string name, input int idx, input logic [5:0] exp);
    @(posedge clk);
    #1;
    chk(name, idx, {btn_level, btn_press, btn_release}, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst       = 1'b1;
    btn       = 2'b00;
    repeat_en = 1'b0;

    // Clean press, repeat off
    add(2'b01, 1'b0, 6,  2'b00, 2'b00, 2'b00);
    add(2'b01, 1'b0, 1,  2'b01, 2'b01, 2'b00);
    add(2'b01, 1'b0, 13, 2'b01, 2'b00, 2'b00);
    add(2'b00, 1'b0, 6,  2'b01, 2'b00, 2'b00);
    add(2'b00, 1'b0, 1,  2'b00, 2'b00, 2'b01);
    add(2'b00, 1'b0, 3,  2'b00, 2'b00, 2'b00);
    // Short glitch ignored
    add(2'b01, 1'b0, 3,  2'b00, 2'b00, 2'b00);
    add(2'b00, 1'b0, 8,  2'b00, 2'b00, 2'b00);
    // Two-cycle dip while held ignored
    add(2'b01, 1'b0, 6,  2'b00, 2'b00, 2'b00);
    add(2'b01, 1'b0, 1,  2'b01, 2'b01, 2'b00);
    add(2'b01, 1'b0, 3,  2'b01, 2'b00, 2'b00);
    add(2'b00, 1'b0, 2,  2'b01, 2'b00, 2'b00);
    add(2'b01, 1'b0, 9,  2'b01, 2'b00, 2'b00);
    add(2'b00, 1'b0, 6,  2'b01, 2'b00, 2'b00);
    add(2'b00, 1'b0, 1,  2'b00, 2'b00, 2'b01);
    add(2'b00, 1'b0, 3,  2'b00, 2'b00, 2'b00);
    // Auto-repeat: presses after 6, 16, 21, 26; release after 34
    add(2'b01, 1'b1, 6,  2'b00, 2'b00, 2'b00);
    add(2'b01, 1'b1, 1,  2'b01, 2'b01, 2'b00);
    add(2'b01, 1'b1, 9,  2'b01, 2'b00, 2'b00);
    add(2'b01, 1'b1, 1,  2'b01, 2'b01, 2'b00);
    add(2'b01, 1'b1, 4,  2'b01, 2'b00, 2'b00);
    add(2'b01, 1'b1, 1,  2'b01, 2'b01, 2'b00);
    add(2'b01, 1'b1, 4,  2'b01, 2'b00, 2'b00);
    add(2'b01, 1'b1, 1,  2'b01, 2'b01, 2'b00);
    add(2'b01, 1'b1, 1,  2'b01, 2'b00, 2'b00);
    add(2'b00, 1'b1, 6,  2'b01, 2'b00, 2'b00);
    add(2'b00, 1'b1, 1,  2'b00, 2'b00, 2'b01);
    add(2'b00, 1'b1, 3,  2'b00, 2'b00, 2'b00);
    // Dip during repeat freezes rcnt: presses after 6, 19, 24; release after 32
    add(2'b01, 1'b1, 6,  2'b00, 2'b00, 2'b00);
    add(2'b01, 1'b1, 1,  2'b01, 2'b01, 2'b00);
    add(2'b01, 1'b1, 3,  2'b01, 2'b00, 2'b00);
    add(2'b00, 1'b1, 2,  2'b01, 2'b00, 2'b00);
    add(2'b01, 1'b1, 7,  2'b01, 2'b00, 2'b00);
    add(2'b01, 1'b1, 1,  2'b01, 2'b01, 2'b00);
    add(2'b01, 1'b1, 4,  2'b01, 2'b00, 2'b00);
    add(2'b01, 1'b1, 1,  2'b01, 2'b01, 2'b00);
    add(2'b01, 1'b1, 1,  2'b01, 2'b00, 2'b00);
    add(2'b00, 1'b1, 6,  2'b01, 2'b00, 2'b00);
    add(2'b00, 1'b1, 1,  2'b00, 2'b00, 2'b01);
    add(2'b00, 1'b1, 3,  2'b00, 2'b00, 2'b00);
    // repeat_en dropped over edges 12-13 restarts delay: presses after 6, 23
    add(2'b01, 1'b1, 6,  2'b00, 2'b00, 2'b00);
    add(2'b01, 1'b1, 1,  2'b01, 2'b01, 2'b00);
    add(2'b01, 1'b1, 5,  2'b01, 2'b00, 2'b00);
    add(2'b01, 1'b0, 2,  2'b01, 2'b00, 2'b00);
    add(2'b01, 1'b1, 9,  2'b01, 2'b00, 2'b00);
    add(2'b01, 1'b1, 1,  2'b01, 2'b01, 2'b00);
    add(2'b01, 1'b1, 1,  2'b01, 2'b00, 2'b00);
    add(2'b00, 1'b1, 6,  2'b01, 2'b00, 2'b00);
    add(2'b00, 1'b1, 1,  2'b00, 2'b00, 2'b01);
    add(2'b00, 1'b1, 3,  2'b00, 2'b00, 2'b00);
    // Simultaneous buttons
    add(2'b11, 1'b0, 6,  2'b00, 2'b00, 2'b00);
    add(2'b11, 1'b0, 1,  2'b11, 2'b11, 2'b00);
    add(2'b11, 1'b0, 3,  2'b11, 2'b00, 2'b00);
    add(2'b00, 1'b0, 6,  2'b11, 2'b00, 2'b00);
    add(2'b00, 1'b0, 1,  2'b00, 2'b00, 2'b11);
    add(2'b00, 1'b0, 3,  2'b00, 2'b00, 2'b00);

    // Reset state
    edge_chk("reset_state", 0, 6'b000000);
    edge_chk("reset_state", 1, 6'b000000);
    rst = 1'b0;

    // Table-driven scenarios
    for (int v = 0; v < vecs.size(); v++) begin
      for (int j = 0; j < vecs[v].n; j++) begin
        btn       = vecs[v].btn;
        repeat_en = vecs[v].ren;
        edge_chk("vec", v, {vecs[v].lvl, vecs[v].prs, vecs[v].rel});
      end
    end

    // Async reset while press pulses are high on both buttons
    btn       = 2'b11;
    repeat_en = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      edge_chk("pre_rst_press", e, (e == 6) ? 6'b111100 : 6'b000000);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_now", 0, {btn_level, btn_press, btn_release}, 6'b000000);
    for (int e = 0; e < 3; e++) begin
      edge_chk("rst_held", e, 6'b000000);
    end
    #3;
    rst = 1'b0;
    // Held through reset: a fresh press after six post-reset edges
    for (int e = 0; e <= 6; e++) begin
      edge_chk("post_rst_press", e, (e == 6) ? 6'b111100 : 6'b000000);
    end
    btn = 2'b00;
    for (int e = 0; e <= 8; e++) begin
      edge_chk("post_rst_release", e,
               (e < 6) ? 6'b110000 : ((e == 6) ? 6'b000011 : 6'b000000));
    end

    // Reset pulsed over edge 4 of a press on button 0
    btn       = 2'b01;
    repeat_en = 1'b0;
    for (int e = 0; e < 4; e++) begin
      edge_chk("mid_press", e, 6'b000000);
    end
    #3;
    rst = 1'b1;
    edge_chk("mid_press", 4, 6'b000000);
    #3;
    rst = 1'b0;
    for (int e = 5; e <= 11; e++) begin
      edge_chk("mid_press", e, (e == 11) ? 6'b010100 : 6'b000000);
    end
    btn = 2'b00;
    for (int e = 0; e <= 7; e++) begin
      edge_chk("mid_press_release", e,
               (e < 6) ? 6'b010000 : ((e == 6) ? 6'b000001 : 6'b000000));
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
`default_nettype wire
